// File: rtl/apb4_timer_seq.sv
// apb4_timer_seq: APB4 master that programs one timer instance, services its
// overflow interrupt for a requested number of periods, then disables it.
//
// Ports
//   clk_i, rst_i          clock / async active-high reset
//   start_i               start request (IDLE only); samples pscr_i, cmp_i, count_i
//   pscr_i, cmp_i         prescaler and compare values written to the timer
//   count_i               periods to run, 0 = run until stopped
//   stop_i                stop request pulse
//   busy_o                state is not IDLE
//   evt_o                 one-cycle pulse per serviced expiry
//   done_o                one-cycle pulse when the disable write completes
//   err_o                 sticky slave-error flag, cleared by the next start
//   paddr_o .. pwdata_o   APB4 requester outputs (write-only)
//   pready_i, pslverr_i   APB4 completer responses
//   irq_i                 timer interrupt level
module apb4_timer_seq #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned CNT_WIDTH = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic [19:0]          pscr_i,
  input  logic [31:0]          cmp_i,
  input  logic [CNT_WIDTH-1:0] count_i,
  input  logic                 stop_i,
  output logic                 busy_o,
  output logic                 evt_o,
  output logic                 done_o,
  output logic                 err_o,
  output logic [31:0]          paddr_o,
  output logic                 psel_o,
  output logic                 penable_o,
  output logic                 pwrite_o,
  output logic [31:0]          pwdata_o,
  input  logic                 pready_i,
  input  logic                 pslverr_i,
  input  logic                 irq_i
);

  localparam int unsigned AW     = 32;
  localparam int unsigned DW     = 32;
  localparam int unsigned PSCR_W = 20;

  localparam logic [AW-1:0] OFS_CTRL = 32'h0000_0000;
  localparam logic [AW-1:0] OFS_PSCR = 32'h0000_0004;
  localparam logic [AW-1:0] OFS_CMP  = 32'h0000_000C;

  // CTRL images: EN=bit1, OVIE=bit2, OVIF=bit0 written as 0 to clear it
  localparam logic [DW-1:0] CTRL_RUN = 32'h0000_0006;
  localparam logic [DW-1:0] CTRL_OFF = 32'h0000_0000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_PSCR,
    S_W_CMP,
    S_W_EN,
    S_WAIT,
    S_W_CLR,
    S_W_DIS
  } state_e;

  state_e                state_q, state_d;
  logic [PSCR_W-1:0]     pscr_q, pscr_d;
  logic [DW-1:0]         cmp_q, cmp_d;
  logic [CNT_WIDTH-1:0]  rem_q, rem_d;
  logic                  stop_pend_q, stop_pend_d;
  logic                  err_q, err_d;
  logic                  evt_q, evt_d;
  logic                  done_q, done_d;
  logic                  busy_q, busy_d;
  logic                  psel_q, psel_d;
  logic                  penable_q, penable_d;
  logic                  pwrite_q, pwrite_d;
  logic [AW-1:0]         paddr_q, paddr_d;
  logic [DW-1:0]         pwdata_q, pwdata_d;
  logic                  xfer_done;

  // State and output registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= S_IDLE;
      pscr_q      <= '0;
      cmp_q       <= '0;
      rem_q       <= '0;
      stop_pend_q <= 1'b0;
      err_q       <= 1'b0;
      evt_q       <= 1'b0;
      done_q      <= 1'b0;
      busy_q      <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
    end else begin
      state_q     <= state_d;
      pscr_q      <= pscr_d;
      cmp_q       <= cmp_d;
      rem_q       <= rem_d;
      stop_pend_q <= stop_pend_d;
      err_q       <= err_d;
      evt_q       <= evt_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
    end
  end

  // Next-state, sequencing and bus-image logic
  always_comb begin
    state_d     = state_q;
    pscr_d      = pscr_q;
    cmp_d       = cmp_q;
    rem_d       = rem_q;
    stop_pend_d = stop_pend_q;
    err_d       = err_q;
    evt_d       = 1'b0;
    done_d      = 1'b0;
    pwrite_d    = 1'b1;
    psel_d      = 1'b0;
    penable_d   = 1'b0;
    paddr_d     = '0;
    pwdata_d    = '0;

    xfer_done = psel_q && penable_q && pready_i;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          pscr_d      = pscr_i;
          cmp_d       = cmp_i;
          rem_d       = count_i;
          err_d       = 1'b0;
          stop_pend_d = 1'b0;
          state_d     = S_W_PSCR;
        end
      end
      S_W_PSCR: if (xfer_done) state_d = S_W_CMP;
      S_W_CMP:  if (xfer_done) state_d = S_W_EN;
      S_W_EN:   if (xfer_done) state_d = S_WAIT;
      S_WAIT: begin
        if (stop_i || stop_pend_q) begin
          state_d = S_W_DIS;
        end else if (irq_i) begin
          state_d = S_W_CLR;
        end
      end
      S_W_CLR: begin
        if (xfer_done) begin
          evt_d = 1'b1;
          if (rem_q == CNT_WIDTH'(1) || stop_pend_q) begin
            state_d = S_W_DIS;
          end else begin
            state_d = S_WAIT;
            // rem==0 means run forever, so it is never decremented
            if (rem_q > CNT_WIDTH'(1)) rem_d = rem_q - CNT_WIDTH'(1);
          end
        end
      end
      S_W_DIS: begin
        if (xfer_done) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Stops seen mid-sequence are deferred to the next WAIT or clear completion
    if (stop_i && state_q != S_IDLE && state_q != S_WAIT) stop_pend_d = 1'b1;

    // A slave error aborts the whole sequence without a disable write
    if (xfer_done && pslverr_i) begin
      err_d   = 1'b1;
      evt_d   = 1'b0;
      done_d  = 1'b0;
      state_d = S_IDLE;
    end

    // Bus image follows the next state so outputs can be registered
    unique case (state_d)
      S_W_PSCR: begin paddr_d = BASE_ADDR + OFS_PSCR; pwdata_d = DW'(pscr_d); end
      S_W_CMP:  begin paddr_d = BASE_ADDR + OFS_CMP;  pwdata_d = cmp_d;       end
      S_W_EN:   begin paddr_d = BASE_ADDR + OFS_CTRL; pwdata_d = CTRL_RUN;    end
      S_W_CLR:  begin paddr_d = BASE_ADDR + OFS_CTRL; pwdata_d = CTRL_RUN;    end
      S_W_DIS:  begin paddr_d = BASE_ADDR + OFS_CTRL; pwdata_d = CTRL_OFF;    end
      default:  begin paddr_d = '0;                   pwdata_d = '0;          end
    endcase

    psel_d = (state_d == S_W_PSCR) || (state_d == S_W_CMP) || (state_d == S_W_EN) ||
             (state_d == S_W_CLR)  || (state_d == S_W_DIS);
    // Staying in the same write state means SETUP->ACCESS or an ACCESS stall
    penable_d = psel_q && (state_d == state_q);
    busy_d    = (state_d != S_IDLE);
  end

  assign busy_o    = busy_q;
  assign evt_o     = evt_q;
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign paddr_o   = paddr_q;
  assign psel_o    = psel_q;
  assign penable_o = penable_q;
  assign pwrite_o  = pwrite_q;
  assign pwdata_o  = pwdata_q;

endmodule

// File: tb/tb_apb4_timer_seq.sv
// Testbench for apb4_timer_seq: APB completer/timer model plus directed steps.
module tb_apb4_timer_seq;

  localparam logic [31:0] BASE = 32'h4000_1000;
  localparam logic [31:0] A_CTRL = BASE;
  localparam logic [31:0] A_PSCR = BASE + 32'h4;
  localparam logic [31:0] A_CMP  = BASE + 32'hC;

  logic        clk, rst;
  logic        start_i, stop_i;
  logic [19:0] pscr_i;
  logic [31:0] cmp_i;
  logic [15:0] count_i;
  logic        busy_o, evt_o, done_o, err_o;
  logic [31:0] paddr_o, pwdata_o;
  logic        psel_o, penable_o, pwrite_o;
  logic        pready, pslverr, irq;

  apb4_timer_seq #(.BASE_ADDR(BASE), .CNT_WIDTH(16)) dut (
    .clk_i(clk), .rst_i(rst), .start_i(start_i), .pscr_i(pscr_i), .cmp_i(cmp_i),
    .count_i(count_i), .stop_i(stop_i), .busy_o(busy_o), .evt_o(evt_o),
    .done_o(done_o), .err_o(err_o), .paddr_o(paddr_o), .psel_o(psel_o),
    .penable_o(penable_o), .pwrite_o(pwrite_o), .pwdata_o(pwdata_o),
    .pready_i(pready), .pslverr_i(pslverr), .irq_i(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef logic [63:0] wr_t;
  wr_t exp_q[$];
  wr_t obs_q[$];
  int  rd = 0;
  int  n_vec = 0;
  int  n_err = 0;

  // Completer/timer model configuration (written by stimulus only)
  int          ready_delay = 0;
  int          irq_req = 0;
  logic        err_en = 1'b0;
  logic [31:0] err_addr = '0;

  // Completer/timer model state (written by the model only)
  int          irq_served = 0;
  int          wait_cnt = 0;
  int          evt_cnt = 0;
  int          done_cnt = 0;
  int          prot_bad = 0;
  logic [31:0] setup_addr = '0;
  logic [31:0] setup_data = '0;

  // APB completer with programmable wait states; timer irq raised per request
  always @(negedge clk) begin
    evt_cnt  <= evt_cnt + int'(evt_o);
    done_cnt <= done_cnt + int'(done_o);
    if (rst) begin
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      irq        <= 1'b0;
      wait_cnt   <= 0;
      irq_served <= irq_req;
    end else if (psel_o && !penable_o) begin
      pready     <= 1'b0;
      pslverr    <= 1'b0;
      wait_cnt   <= 0;
      setup_addr <= paddr_o;
      setup_data <= pwdata_o;
      if (!pwrite_o) prot_bad <= prot_bad + 1;
    end else if (psel_o && penable_o) begin
      if (paddr_o !== setup_addr || pwdata_o !== setup_data) prot_bad <= prot_bad + 1;
      if (wait_cnt >= ready_delay) begin
        pready   <= 1'b1;
        pslverr  <= err_en && (paddr_o == err_addr);
        wait_cnt <= 0;
        obs_q.push_back({paddr_o, pwdata_o});
        if (paddr_o == A_CTRL) irq <= 1'b0;
      end else begin
        pready   <= 1'b0;
        pslverr  <= 1'b0;
        wait_cnt <= wait_cnt + 1;
      end
    end else begin
      pready  <= 1'b0;
      pslverr <= 1'b0;
      if (!irq && busy_o && irq_served < irq_req) begin
        irq        <= 1'b1;
        irq_served <= irq_served + 1;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic expect_wr(input logic [31:0] a, input logic [31:0] d);
    exp_q.push_back({a, d});
  endtask

  task automatic expect_cfg(input logic [19:0] p, input logic [31:0] c);
    expect_wr(A_PSCR, 32'(p));
    expect_wr(A_CMP, c);
    expect_wr(A_CTRL, 32'h6);
  endtask

  // Pop expected writes and compare against writes the completer has seen
  task automatic drain(input string tag);
    wr_t e;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (rd < obs_q.size()) begin
        check(tag, obs_q[rd], e);
        rd++;
      end else begin
        check({tag, "_missing"}, 64'(obs_q.size()), 64'(rd + 1));
        rd++;
      end
    end
    check({tag, "_extra"}, 64'(obs_q.size()), 64'(rd));
    rd = obs_q.size();
  endtask

  task automatic do_start(input logic [19:0] p, input logic [31:0] c, input logic [15:0] n);
    @(negedge clk);
    start_i = 1'b1; pscr_i = p; cmp_i = c; count_i = n;
    @(negedge clk);
    start_i = 1'b0;
  endtask

  task automatic pulse_stop();
    stop_i = 1'b1;
    @(negedge clk);
    stop_i = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int k;
    k = 0;
    while (!done_o && k < budget) begin
      @(negedge clk);
      k++;
    end
    check(tag, 64'(k < budget), 64'(1));
    @(negedge clk);
  endtask

  initial begin
    int e0, d0, cyc, first_wait, first_evt, k;

    rst = 1'b1; start_i = 1'b0; stop_i = 1'b0;
    pscr_i = '0; cmp_i = '0; count_i = '0;
    repeat (3) @(negedge clk);
    check("rst_ctrl", 64'({busy_o, evt_o, done_o, err_o, psel_o, penable_o, pwrite_o}), 64'(0));
    check("rst_bus", {paddr_o, pwdata_o}, 64'(0));
    rst = 1'b0;
    @(negedge clk);

    // Basic run: count=2 with latency checks
    irq_req = irq_req + 2;
    expect_cfg(20'd4, 32'd9);
    expect_wr(A_CTRL, 32'h6); expect_wr(A_CTRL, 32'h6); expect_wr(A_CTRL, 32'h0);
    e0 = evt_cnt; d0 = done_cnt;
    @(negedge clk);
    start_i = 1'b1; pscr_i = 20'd4; cmp_i = 32'd9; count_i = 16'd2;
    cyc = 0; first_wait = -1; first_evt = -1;
    while (!done_o && cyc < 200) begin
      @(negedge clk);
      start_i = 1'b0;
      cyc++;
      if (cyc == 1) check("busy_rise", 64'(busy_o), 64'(1));
      if (first_wait < 0 && busy_o && !psel_o) first_wait = cyc;
      if (first_evt < 0 && evt_o) first_evt = cyc;
    end
    check("basic_done_seen", 64'(cyc < 200), 64'(1));
    check("lat_start_wait", 64'(first_wait), 64'(7));
    check("lat_irq_evt", 64'(first_evt), 64'(10));
    @(negedge clk);
    @(negedge clk);
    check("basic_busy", 64'(busy_o), 64'(0));
    check("basic_evt", 64'(evt_cnt - e0), 64'(2));
    check("basic_done", 64'(done_cnt - d0), 64'(1));
    check("basic_err", 64'(err_o), 64'(0));
    drain("basic_wr");

    // Infinite run: 5 expiries, then stop in WAIT
    e0 = evt_cnt; d0 = done_cnt;
    irq_req = irq_req + 5;
    expect_cfg(20'hABCDE, 32'hDEAD_BEEF);
    for (int i = 0; i < 5; i++) expect_wr(A_CTRL, 32'h6);
    expect_wr(A_CTRL, 32'h0);
    do_start(20'hABCDE, 32'hDEAD_BEEF, 16'd0);
    k = 0;
    while (evt_cnt - e0 < 5 && k < 300) begin @(negedge clk); k++; end
    repeat (4) @(negedge clk);
    check("inf_evt", 64'(evt_cnt - e0), 64'(5));
    check("inf_still_busy", 64'(busy_o), 64'(1));
    check("inf_no_done", 64'(done_cnt - d0), 64'(0));
    pulse_stop();
    wait_done("inf_done_seen", 50);
    @(negedge clk);
    check("inf_busy", 64'(busy_o), 64'(0));
    check("inf_done", 64'(done_cnt - d0), 64'(1));
    drain("inf_wr");

    // Stop during W_CMP with 3 wait states: EN still written, no clear
    ready_delay = 3;
    e0 = evt_cnt; d0 = done_cnt;
    expect_cfg(20'h00011, 32'h0000_1234);
    expect_wr(A_CTRL, 32'h0);
    do_start(20'h00011, 32'h0000_1234, 16'd3);
    k = 0;
    while (!(psel_o && paddr_o == A_CMP) && k < 50) begin @(negedge clk); k++; end
    check("stop_cmp_reached", 64'(k < 50), 64'(1));
    pulse_stop();
    wait_done("stop_done_seen", 100);
    @(negedge clk);
    check("stop_evt", 64'(evt_cnt - e0), 64'(0));
    check("stop_done", 64'(done_cnt - d0), 64'(1));
    check("stop_busy", 64'(busy_o), 64'(0));
    drain("stop_wr");
    ready_delay = 0;

    // Slave error on W_CMP: abort, sticky err, no EN write
    err_en = 1'b1; err_addr = A_CMP;
    e0 = evt_cnt; d0 = done_cnt;
    expect_wr(A_PSCR, 32'h2); expect_wr(A_CMP, 32'h77);
    do_start(20'h2, 32'h77, 16'd1);
    k = 0;
    while (busy_o && k < 50) begin @(negedge clk); k++; end
    repeat (5) @(negedge clk);
    check("slverr_err", 64'(err_o), 64'(1));
    check("slverr_idle", 64'({busy_o, psel_o, penable_o}), 64'(0));
    check("slverr_no_done", 64'(done_cnt - d0), 64'(0));
    check("slverr_no_evt", 64'(evt_cnt - e0), 64'(0));
    drain("slverr_wr");
    err_en = 1'b0;
    irq_req = irq_req + 1;
    expect_cfg(20'h3, 32'h88);
    expect_wr(A_CTRL, 32'h6); expect_wr(A_CTRL, 32'h0);
    do_start(20'h3, 32'h88, 16'd1);
    check("restart_err_clr", 64'(err_o), 64'(0));
    wait_done("restart_done_seen", 100);
    check("restart_err", 64'(err_o), 64'(0));
    drain("restart_wr");

    // Ignored inputs: stop in IDLE, start while busy
    pulse_stop();
    repeat (4) @(negedge clk);
    check("idle_stop", 64'({busy_o, psel_o}), 64'(0));
    drain("idle_stop_wr");
    ready_delay = 2;
    e0 = evt_cnt;
    irq_req = irq_req + 1;
    expect_cfg(20'h7, 32'h55);
    expect_wr(A_CTRL, 32'h6); expect_wr(A_CTRL, 32'h0);
    do_start(20'h7, 32'h55, 16'd1);
    start_i = 1'b1; pscr_i = 20'hFFFFF; cmp_i = 32'hAA; count_i = 16'd5;
    @(negedge clk);
    start_i = 1'b0;
    wait_done("ign_done_seen", 100);
    check("ign_evt", 64'(evt_cnt - e0), 64'(1));
    drain("ign_wr");
    ready_delay = 0;

    // Async reset in W_CLR ACCESS phase
    expect_cfg(20'h9, 32'h99);
    do_start(20'h9, 32'h99, 16'd0);
    k = 0;
    while (!(busy_o && !psel_o) && k < 50) begin @(negedge clk); k++; end
    drain("rst_cfg_wr");
    ready_delay = 60;
    irq_req = irq_req + 1;
    k = 0;
    while (!(psel_o && penable_o && paddr_o == A_CTRL) && k < 50) begin @(negedge clk); k++; end
    check("rst_clr_access", 64'({psel_o, penable_o, pwdata_o}), 64'({2'b11, 32'h6}));
    #2 rst = 1'b1;
    #1;
    check("rst_async_ctrl", 64'({busy_o, evt_o, done_o, err_o, psel_o, penable_o, pwrite_o}), 64'(0));
    check("rst_async_bus", {paddr_o, pwdata_o}, 64'(0));
    @(negedge clk);
    rst = 1'b0;
    ready_delay = 0;
    repeat (3) @(negedge clk);
    check("rst_post_idle", 64'({busy_o, psel_o, penable_o}), 64'(0));
    drain("rst_wr");

    check("apb_protocol", 64'(prot_bad), 64'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/apb4_timer_seq.md
Name: apb4_timer_seq

Overview:
- APB4 master-side sequencer that configures and services one APB4 timer instance.
- On a start request it programs the prescaler, compare and control registers, then waits on the timer interrupt.
- On each expiry it clears the overflow flag, emits an event pulse and counts periods.
- When the period count is exhausted or a stop is requested, it disables the timer.

Parameters:
- BASE_ADDR, 32'h0000_0000, APB byte address of the timer's register block.
- CNT_WIDTH, 16, width of the period-count request field.

Ports:
- clk_i  in  1  clock; also drives the APB pclk domain.
- rst_i  in  1  asynchronous, active-high reset.
- start_i  in  1  request pulse; accepted only in IDLE.
- pscr_i  in  20  prescaler value, sampled at start.
- cmp_i  in  32  compare value, sampled at start.
- count_i  in  CNT_WIDTH  number of periods to run; 0 = run until stopped. Sampled at start.
- stop_i  in  1  stop request pulse.
- busy_o  out  1  high whenever the state is not IDLE.
- evt_o  out  1  one-cycle pulse per serviced expiry.
- done_o  out  1  one-cycle pulse when the disable write completes.
- err_o  out  1  sticky; set on pslverr; cleared by the next accepted start.
- paddr_o  out  32  APB address.
- psel_o  out  1  APB select.
- penable_o  out  1  APB enable.
- pwrite_o  out  1  APB direction; always 1.
- pwdata_o  out  32  APB write data.
- pready_i  in  1  APB ready.
- pslverr_i  in  1  APB error.
- irq_i  in  1  timer interrupt, level; stays high until OVIF is cleared.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal registers 0.
- States: IDLE, W_PSCR, W_CMP, W_EN, WAIT, W_CLR, W_DIS.
- Each W_* state performs one APB write in two phases:
  - SETUP phase, 1 cycle: psel=1, penable=0.
  - ACCESS phase: psel=1, penable=1, held until pready_i=1.
  - paddr_o and pwdata_o are stable across both phases.
- Outside W_* states: psel, penable, paddr and pwdata are all 0.
- Write targets (address, data):
  - W_PSCR: BASE+0x04, zero-extended pscr.
  - W_CMP: BASE+0x0C, cmp.
  - W_EN: BASE+0x00, 0x6 (EN=1, OVIE=1, OVIF=0).
  - W_CLR: BASE+0x00, 0x6 (writing 0 to OVIF clears it; EN stays 1).
  - W_DIS: BASE+0x00, 0x0.
- Transitions:
  - IDLE: start_i=1 latches pscr, cmp and count into rem; clears err and stop_pend; goes to W_PSCR.
  - W_PSCR -> W_CMP -> W_EN -> WAIT, each on ACCESS with pready.
  - WAIT: stop_i=1 or stop_pend=1 -> W_DIS (stop has priority); else irq_i=1 -> W_CLR.
  - W_CLR completion: evt_o pulses in that cycle.
    - If rem==1 or stop_pend=1 -> W_DIS.
    - Else -> WAIT; rem decrements when rem>1.
    - rem==0 never decrements (infinite run).
  - W_DIS completion: done_o pulses in that cycle; state goes to IDLE.
- The timer updates its CTRL register at the ACCESS/pready edge, so irq_i is already low on the first WAIT cycle after W_CLR. No extra masking of irq_i is needed.
- stop_i outside WAIT and IDLE sets stop_pend; it is honoured at the next WAIT entry or W_CLR completion.
- stop_i in IDLE is ignored.
- start_i outside IDLE is ignored and does not disturb the latched configuration.
- pslverr_i=1 with pready in any ACCESS phase: err_o=1, no evt/done pulse, state goes to IDLE immediately (no disable write).
- Reset mid-transfer drops psel and penable asynchronously and returns the FSM to IDLE.
- Minimum latency, pready tied high: start to first WAIT cycle = 6 cycles; irq rising to evt_o = 2 cycles.

Test Plan:
- Basic run: start, pscr=4, cmp=9, count=2, pready=1 -> writes issued in order (0x04,4), (0x0C,9), (0x00,6); 2 irqs give 2 evt_o pulses, then write (0x00,0), done_o, busy_o=0.
- Infinite run: count=0 with 5 irqs -> 5 evt_o pulses and 5 clear writes. stop_i in WAIT -> disable write, done_o.
- Stop during W_CMP with pready delayed 3 cycles -> setup and access phases stretched correctly; W_EN still issued; then W_DIS without entering W_CLR; done_o.
- pslverr on W_CMP -> err_o=1, FSM back in IDLE, no W_EN write. A new start clears err_o.
- Ignored inputs: start_i while busy and stop_i in IDLE -> no bus activity change, latched values unchanged.
- Async reset asserted in the W_CLR ACCESS phase -> psel/penable drop within the same cycle, all outputs 0, FSM in IDLE.
